icache_direct_mapped: RTL

//  Direct-mapped instruction cache between the instruction fetcher and the memory controller.
//  - Serves word-aligned 32-bit instruction fetches from on-chip storage.
//  - On a miss, raises fet_ena with a word address, waits for the memory controller's
//    one-cycle valid pulse, fills the line, then answers the fetcher.
//  - One word per line, no write path (instruction memory is read-only here).

---
 rtl/icache_direct_mapped_pkg.sv | 15 +
 rtl/icache_line_array.sv | 48 ++++
 rtl/icache_direct_mapped.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/icache_direct_mapped_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package icache_direct_mapped_pkg;

   // Geometry: one 32-bit word per line, word-aligned addresses.
   localparam int ICACHE_INDEX_BITS = 6;
   localparam int ICACHE_TAG_BITS   = 30 - ICACHE_INDEX_BITS;
   localparam int ICACHE_DATA_W     = 32;

   // Controller state: IDLE serves hits, MISS waits for and completes a refill.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MISS = 1'b1
   } icache_state_e;

endpackage

// File: rtl/icache_line_array.sv
// Line storage: valid/tag/data per line, combinational read, one write port,
// valid bits cleared by synchronous reset.
module icache_line_array
   import icache_direct_mapped_pkg::*;
#(
   parameter int INDEX_BITS = ICACHE_INDEX_BITS,
   parameter int TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [INDEX_BITS-1:0]    rd_index_i,
   output logic                     rd_valid_o,
   output logic [TAG_BITS-1:0]      rd_tag_o,
   output logic [ICACHE_DATA_W-1:0] rd_data_o,
   input  logic                     wr_en_i,
   input  logic [INDEX_BITS-1:0]    wr_index_i,
   input  logic [TAG_BITS-1:0]      wr_tag_i,
   input  logic [ICACHE_DATA_W-1:0] wr_data_i
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]         valid_q;
   logic [TAG_BITS-1:0]      tag_q  [LINES];
   logic [ICACHE_DATA_W-1:0] data_q [LINES];

   // Valid bits: cleared on reset, set when a line is filled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_index_i] <= 1'b1;
      end
   end

   // Tag and data payload: no reset needed, qualified by the valid bit.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_q[wr_index_i]  <= wr_tag_i;
         data_q[wr_index_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_tag_o   = tag_q[rd_index_i];
   assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache: 1-cycle hits from local storage, misses
// refilled through the memory controller (fet_ena / valid_from_mc).
//
// Handshake: fetch_req/fetch_pc are held by the fetcher until fetch_valid
// pulses for one cycle; every IDLE cycle with fetch_req=1 is a new request.
// fet_ena is a level held with a stable instr_addr until valid_from_mc pulses;
// fet_ena drops one edge after the fill. fetch_clear cancels the response.
module icache_direct_mapped
   import icache_direct_mapped_pkg::*;
#(
   parameter int INDEX_BITS = ICACHE_INDEX_BITS
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rdy,
   input  logic          fetch_req,
   input  logic [31:0]   fetch_pc,
   input  logic          fetch_clear,
   output logic          fetch_valid,
   output logic [31:0]   fetch_instr,
   output logic          fet_ena,
   output logic [31:0]   instr_addr,
   input  logic          valid_from_mc,
   input  logic [31:0]   data_from_mc,
   output icache_state_e dbg_state_o
);

   localparam int TAG_BITS = 30 - INDEX_BITS;

   icache_state_e state_q, state_d;
   logic          fill_q, fill_d;          // line written, response due next edge
   logic          drop_q, drop_d;          // outstanding miss was flushed
   logic          fet_ena_q, fet_ena_d;
   logic [31:0]   instr_addr_q, instr_addr_d;
   logic          fetch_valid_q, fetch_valid_d;
   logic [31:0]   fetch_instr_q, fetch_instr_d;

   logic [INDEX_BITS-1:0] rd_index;
   logic                  rd_valid;
   logic [TAG_BITS-1:0]   rd_tag;
   logic [31:0]           rd_data;
   logic                  hit;
   logic                  wr_en;
   logic [1:0]            unused_pc_lsbs;

   // The latched refill address doubles as the miss index/tag.
   assign rd_index = (state_q == ST_MISS) ? instr_addr_q[INDEX_BITS+1:2]
                                          : fetch_pc[INDEX_BITS+1:2];
   assign hit      = rd_valid && (rd_tag == fetch_pc[31:INDEX_BITS+2]);
   assign wr_en    = rst_n && rdy && (state_q == ST_MISS) && !fill_q && valid_from_mc;
   assign unused_pc_lsbs = fetch_pc[1:0];

   icache_line_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_lines (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_index_i (rd_index),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .wr_en_i    (wr_en),
      .wr_index_i (instr_addr_q[INDEX_BITS+1:2]),
      .wr_tag_i   (instr_addr_q[31:INDEX_BITS+2]),
      .wr_data_i  (data_from_mc)
   );

   // Next-state and output decisions; fetch_valid defaults low so it only pulses.
   always_comb begin
      state_d       = state_q;
      fill_d        = fill_q;
      drop_d        = drop_q;
      fet_ena_d     = fet_ena_q;
      instr_addr_d  = instr_addr_q;
      fetch_valid_d = 1'b0;
      fetch_instr_d = fetch_instr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (fetch_req && !fetch_clear) begin
               if (hit) begin
                  fetch_valid_d = 1'b1;
                  fetch_instr_d = rd_data;
               end else begin
                  fet_ena_d    = 1'b1;
                  instr_addr_d = {fetch_pc[31:2], 2'b00};
                  drop_d       = 1'b0;
                  fill_d       = 1'b0;
                  state_d      = ST_MISS;
               end
            end
         end
         ST_MISS: begin
            if (fill_q) begin
               // Line already written; answer from storage unless flushed.
               fet_ena_d     = 1'b0;
               fetch_valid_d = !(drop_q || fetch_clear);
               if (!(drop_q || fetch_clear)) begin
                  fetch_instr_d = rd_data;
               end
               drop_d  = 1'b0;
               fill_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               if (valid_from_mc) begin
                  fill_d = 1'b1;
               end
               if (fetch_clear) begin
                  drop_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; rdy low freezes everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         fill_q        <= 1'b0;
         drop_q        <= 1'b0;
         fet_ena_q     <= 1'b0;
         instr_addr_q  <= '0;
         fetch_valid_q <= 1'b0;
         fetch_instr_q <= '0;
      end else if (rdy) begin
         state_q       <= state_d;
         fill_q        <= fill_d;
         drop_q        <= drop_d;
         fet_ena_q     <= fet_ena_d;
         instr_addr_q  <= instr_addr_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_instr_q <= fetch_instr_d;
      end
   end

   assign fetch_valid = fetch_valid_q;
   assign fetch_instr = fetch_instr_q;
   assign fet_ena     = fet_ena_q;
   assign instr_addr  = instr_addr_q;
   assign dbg_state_o = state_q;

endmodule
